cla_nibble_seq: RTL and testbench

CLA_NIBBLE_SEQ -- requirements
Module: cla_nibble_seq

---
 rtl/cla_nibble_seq_if.sv | 29 ++
 rtl/cla_nibble_seq.sv | 95 +++++++++
 tb/tb_cla_nibble_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/cla_nibble_seq_if.sv
// Request/result bus of the nibble-serial adder plus the handshake with the
// external registered 4-bit CLA stage.
interface cla_nibble_seq_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout_out;
  logic [3:0]   add_x;
  logic [3:0]   add_y;
  logic         add_cin;
  logic [3:0]   add_z;
  logic         add_cout;

  modport master (
    output start, a, b, cin_in, add_z, add_cout,
    input  busy, done, sum, cout_out, add_x, add_y, add_cin
  );

  modport slave (
    input  start, a, b, cin_in, add_z, add_cout,
    output busy, done, sum, cout_out, add_x, add_y, add_cin
  );
endinterface

// File: rtl/cla_nibble_seq.sv
// Sequential W-bit adder: walks the operands one nibble at a time through an
// external registered 4-bit CLA stage, rippling the carry between nibbles.
module cla_nibble_seq #(
  parameter int N_NIB = 4,
  parameter int LAT   = 2
) (
  input  logic            clk,
  input  logic            res,
  cla_nibble_seq_if.slave bus
);
  localparam int W    = 4 * N_NIB;
  localparam int IDXW = (N_NIB > 1) ? $clog2(N_NIB) : 1;
  localparam int WCW  = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] { IDLE, ISSUE, WAIT, DONE } state_t;
  state_t state, state_nxt;

  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry_q;
  logic [IDXW-1:0] idx;
  logic [WCW-1:0]  wcnt;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            wait_last;
  logic            nib_last;

  always_comb begin
    wait_last = (wcnt == WCW'(LAT - 1));
    nib_last  = (idx == IDXW'(N_NIB - 1));
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_last) state_nxt = nib_last ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latched operands shift right one nibble per step, so the current nibble
  // always sits in [3:0]; the running carry doubles as the stage carry-in
  // (it holds the latched cin_in for nibble 0).
  always_comb begin
    bus.busy     = (state != IDLE);
    bus.done     = (state == DONE);
    bus.sum      = sum_q;
    bus.cout_out = cout_q;
    bus.add_x    = a_q[3:0];
    bus.add_y    = b_q[3:0];
    bus.add_cin  = carry_q;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      wcnt    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin_in;
            idx     <= '0;
          end
        end
        ISSUE: wcnt <= '0;
        WAIT: begin
          if (wait_last) begin
            sum_q[4*idx +: 4] <= bus.add_z;
            carry_q           <= bus.add_cout;
            if (nib_last) begin
              cout_q <= bus.add_cout;
            end else begin
              idx <= idx + 1'b1;
              a_q <= a_q >> 4;
              b_q <= b_q >> 4;
            end
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_nibble_seq.sv
// Bench for cla_nibble_seq: models the registered CLA stage, predicts every
// output cycle by cycle from plain arithmetic, and pins key cycles by hand.
module tb_cla_nibble_seq;
  localparam int N_NIB = 4;
  localparam int LAT   = 2;
  localparam int W     = 4 * N_NIB;
  localparam int T     = N_NIB * (LAT + 1) + 1;

  logic clk = 1'b0;
  logic res;

  cla_nibble_seq_if #(.W(W)) bus ();
  cla_nibble_seq #(.N_NIB(N_NIB), .LAT(LAT)) dut (.clk(clk), .res(res), .bus(bus));

  always #5 clk = ~clk;

  // External 4-bit adder stage with LAT register levels, sharing res.
  logic [4:0] pipe [LAT];
  always @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {1'b0, bus.add_x} + {1'b0, bus.add_y} + {4'b0, bus.add_cin};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign bus.add_z    = pipe[LAT-1][3:0];
  assign bus.add_cout = pipe[LAT-1][4];

  // Transaction-level model: one accepted start at cycle m_t0, result at m_t0+T.
  int           cyc = 0;
  bit           m_act = 1'b0;
  bit           m_have = 1'b0;
  int           m_t0 = 0;
  logic [W-1:0] m_a, m_b, m_sum, m_last_sum;
  logic         m_cin, m_cout, m_last_cout;

  function automatic bit in_op(int c);
    return m_act && (c > m_t0) && (c <= m_t0 + T);
  endfunction

  function automatic logic carry_into(int k);
    logic [63:0] msk, s;
    msk = (64'd1 << (4 * k)) - 64'd1;
    s   = (64'(m_a) & msk) + (64'(m_b) & msk) + 64'(m_cin);
    return s[4*k];
  endfunction

  always @(posedge clk) begin
    if (res) begin
      m_act  <= 1'b0;
      m_have <= 1'b0;
    end else begin
      if (m_act && cyc == m_t0 + T) begin
        m_have      <= 1'b1;
        m_last_sum  <= m_sum;
        m_last_cout <= m_cout;
      end
      if (!in_op(cyc) && bus.start) begin
        m_act <= 1'b1;
        m_t0  <= cyc;
        m_a   <= bus.a;
        m_b   <= bus.b;
        m_cin <= bus.cin_in;
        {m_cout, m_sum} <= {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.cin_in};
      end
    end
    cyc <= cyc + 1;
  end

  typedef enum { P_SUM, P_COUT, P_DONE, P_BUSY, P_ACIN } psel_t;
  typedef struct {
    int          c;
    psel_t       s;
    logic [63:0] v;
    string       nm;
  } pin_t;
  pin_t pins[$];

  task automatic pin(int c, psel_t s, logic [63:0] v, string nm);
    pin_t p;
    p.c  = c;
    p.s  = s;
    p.v  = v;
    p.nm = nm;
    pins.push_back(p);
  endtask

  function automatic logic [63:0] pin_act(psel_t s);
    case (s)
      P_SUM:   return 64'(bus.sum);
      P_COUT:  return 64'(bus.cout_out);
      P_DONE:  return 64'(bus.done);
      P_BUSY:  return 64'(bus.busy);
      P_ACIN:  return 64'(bus.add_cin);
      default: return '0;
    endcase
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : cmp
    int rel;
    int k;
    if (res) begin
      chk("rst_busy",     64'(bus.busy),     64'd0);
      chk("rst_done",     64'(bus.done),     64'd0);
      chk("rst_sum",      64'(bus.sum),      64'd0);
      chk("rst_cout",     64'(bus.cout_out), 64'd0);
      chk("rst_add_x",    64'(bus.add_x),    64'd0);
      chk("rst_add_y",    64'(bus.add_y),    64'd0);
      chk("rst_add_cin",  64'(bus.add_cin),  64'd0);
    end else begin
      rel = cyc - m_t0;
      chk("busy", 64'(bus.busy), 64'(in_op(cyc)));
      chk("done", 64'(bus.done), 64'(m_act && rel == T));
      if (m_act && rel == T) begin
        chk("sum",  64'(bus.sum),      64'(m_sum));
        chk("cout", 64'(bus.cout_out), 64'(m_cout));
      end else if (!in_op(cyc)) begin
        chk("sum_hold",  64'(bus.sum),      m_have ? 64'(m_last_sum)  : 64'd0);
        chk("cout_hold", 64'(bus.cout_out), m_have ? 64'(m_last_cout) : 64'd0);
      end
      if (in_op(cyc) && rel < T) begin
        k = (rel - 1) / (LAT + 1);
        chk("add_x",   64'(bus.add_x),   64'(4'(m_a >> (4 * k))));
        chk("add_y",   64'(bus.add_y),   64'(4'(m_b >> (4 * k))));
        chk("add_cin", 64'(bus.add_cin), 64'(carry_into(k)));
      end
    end
    foreach (pins[i])
      if (pins[i].c == cyc) chk(pins[i].nm, pin_act(pins[i].s), pins[i].v);
  end

  task automatic at_cycle(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(logic s, logic [W-1:0] av, logic [W-1:0] bv, logic ci);
    bus.start  = s;
    bus.a      = av;
    bus.b      = bv;
    bus.cin_in = ci;
  endtask

  initial begin
    res = 1'b1;
    drive(1'b0, '0, '0, 1'b0);

    pin(3,  P_BUSY, 0, "idle_busy");     pin(3,  P_SUM,  0, "idle_sum");
    pin(4,  P_BUSY, 0, "op1_busy_c0");   pin(5,  P_BUSY, 1, "op1_busy_c1");
    pin(16, P_DONE, 0, "op1_done_c12");  pin(17, P_DONE, 1, "op1_done_c13");
    pin(17, P_BUSY, 1, "op1_busy_c13");  pin(17, P_SUM,  64'h5555, "op1_sum");
    pin(17, P_COUT, 0, "op1_cout");      pin(18, P_BUSY, 0, "op1_busy_c14");
    pin(18, P_DONE, 0, "op1_done_c14");
    pin(21, P_ACIN, 0, "op2_cin_n0");    pin(24, P_ACIN, 1, "op2_cin_n1");
    pin(27, P_ACIN, 1, "op2_cin_n2");    pin(30, P_ACIN, 1, "op2_cin_n3");
    pin(33, P_SUM,  0, "op2_sum");       pin(33, P_COUT, 1, "op2_cout");
    pin(33, P_DONE, 1, "op2_done");
    pin(37, P_ACIN, 1, "op3_cin_n0");    pin(49, P_SUM,  0, "op3_sum");
    pin(49, P_COUT, 1, "op3_cout");      pin(49, P_DONE, 1, "op3_done");
    pin(65, P_DONE, 1, "op4_done");      pin(65, P_SUM,  64'h2020, "op4_sum");
    pin(65, P_COUT, 0, "op4_cout");      pin(66, P_BUSY, 0, "restart_idle");
    pin(67, P_BUSY, 1, "restart_busy");  pin(78, P_DONE, 0, "op5_done_early");
    pin(79, P_DONE, 1, "op5_done");      pin(79, P_SUM,  64'h0001, "op5_sum");
    pin(79, P_COUT, 1, "op5_cout");
    pin(88, P_BUSY, 0, "midrst_busy");   pin(88, P_COUT, 0, "midrst_cout");
    pin(90, P_SUM,  0, "postrst_sum");   pin(95, P_DONE, 0, "abandoned_done");
    pin(110, P_DONE, 1, "op7_done");     pin(110, P_SUM, 64'h0010, "op7_sum");
    pin(110, P_COUT, 0, "op7_cout");

    at_cycle(2);  res = 1'b0;

    // Operands scrambled on every busy cycle must not disturb the result.
    at_cycle(4);  drive(1'b1, 16'h1234, 16'h4321, 1'b0);
    for (int c = 5; c <= 17; c++) begin
      at_cycle(c);
      drive(1'b0, W'($urandom), W'($urandom), 1'($urandom));
    end

    at_cycle(20); drive(1'b1, 16'hFFFF, 16'h0001, 1'b0);
    at_cycle(21); bus.start = 1'b0;

    at_cycle(36); drive(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    at_cycle(37); bus.start = 1'b0;

    at_cycle(52); drive(1'b1, 16'h0F0F, 16'h1111, 1'b0);
    at_cycle(53); bus.start = 1'b0;
    at_cycle(57); drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    at_cycle(58); bus.start = 1'b0;
    at_cycle(65); drive(1'b1, 16'h1234, 16'h1111, 1'b1);
    at_cycle(66); drive(1'b1, 16'h8000, 16'h8000, 1'b1);
    at_cycle(67); bus.start = 1'b0;

    at_cycle(82); drive(1'b1, 16'h00F0, 16'h0010, 1'b0);
    at_cycle(83); bus.start = 1'b0;
    at_cycle(88); res = 1'b1;
    at_cycle(89); res = 1'b0;
    at_cycle(97); drive(1'b1, 16'h000F, 16'h0001, 1'b0);
    at_cycle(98); bus.start = 1'b0;

    at_cycle(115);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
